// File: rtl/instr_stream_feeder_if.sv
// ---------------------------------------------------------------------------
// instr_stream_feeder_if
//   Bundles the program loader, stream control and stream output signals of
//   instr_stream_feeder.
//
//   master : loader/bench side. It drives the write port, prog_len, start
//            and hold, and it observes the stream.
//   slave  : feeder side. It receives the controls and drives the stream.
//
//   wr_en/wr_addr/wr_data : program memory write port
//   prog_len              : words to stream, sampled when a start is accepted
//   start, hold           : begin streaming / stall the stream
//   dout, dout_valid      : word for the processor din input, and its qualifier
//   is_imm                : dout is the immediate operand of an mvi (opcode 01)
//   pc                    : address of the word currently on dout
//   busy, done            : running / one-cycle end-of-program pulse
// ---------------------------------------------------------------------------
interface instr_stream_feeder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   prog_len;
  logic              start;
  logic              hold;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              is_imm;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, prog_len, start, hold,
    input  dout, dout_valid, is_imm, pc, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, prog_len, start, hold,
    output dout, dout_valid, is_imm, pc, busy, done
  );
endinterface

// File: rtl/instr_stream_feeder.sv
// ---------------------------------------------------------------------------
// instr_stream_feeder
//   Program-memory sequencer for the lab processor's din input. It holds a
//   small loadable program. After an accepted start, it presents one word per
//   clock. It tags each word that is the immediate operand of an mvi
//   (opcode 01). It pulses done for one cycle after the last word.
//
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : instr_stream_feeder_if.slave, which carries the write port,
//          prog_len/start/hold and dout/dout_valid/is_imm/pc/busy/done
// ---------------------------------------------------------------------------
module instr_stream_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_stream_feeder_if.slave  bus
);

  localparam int                LEN_W     = ADDR_W + 1;
  localparam logic [LEN_W-1:0]  DEPTH_LEN = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] word_q;
  logic [ADDR_W-1:0] pc_q;
  logic              imm_q;
  logic [LEN_W-1:0]  len_q;

  logic              accept;
  logic              last;
  logic              advance;
  logic [ADDR_W-1:0] pc_next;
  logic              imm_next;

  // -------------------------------------------------------------------------
  // Program memory
  // -------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Clearing it would turn it into
  // DEPTH resettable flops instead of a plain RAM, and the loader always
  // writes a program before it starts a run.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  assign accept   = (state_q == IDLE) && bus.start && (bus.prog_len != '0);
  assign last     = ({1'b0, pc_q} == (len_q - LEN_W'(1)));
  assign advance  = (state_q == RUN) && !bus.hold && !last;
  assign pc_next  = pc_q + ADDR_W'(1);
  // A word that is itself an immediate never marks its successor. An operand
  // whose top bits happen to be 01 therefore cannot chain.
  assign imm_next = (word_q[DATA_W-1 -: 2] == 2'b01) && !imm_q;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only. Every register
  // then samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_d gets its default before the case. No path can leave it
  // unassigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (!bus.hold && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Stream datapath: the presented word, its address, the immediate tag and
  // the latched run length. The memory read is registered, so a same-address
  // write in the same cycle is seen only on a later read.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      pc_q   <= '0;
      imm_q  <= 1'b0;
      len_q  <= '0;
    end else if (accept) begin
      word_q <= mem[0];
      pc_q   <= '0;
      imm_q  <= 1'b0;
      len_q  <= (bus.prog_len > DEPTH_LEN) ? DEPTH_LEN : bus.prog_len;
    end else if (advance) begin
      word_q <= mem[pc_next];
      pc_q   <= pc_next;
      imm_q  <= imm_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. The stream shows only in RUN. IDLE and DONE present zeros,
  // so an asynchronous reset also zeros the outputs at once.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.dout       = '0;
    bus.dout_valid = 1'b0;
    bus.is_imm     = 1'b0;
    bus.pc         = '0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    unique case (state_q)
      RUN: begin
        bus.dout       = word_q;
        bus.dout_valid = 1'b1;
        bus.is_imm     = imm_q;
        bus.pc         = pc_q;
        bus.busy       = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
